serial_parity_checker: RTL and testbench

Bit-serial receiver that assembles WORD_BITS data bits, LSB first, followed by one parity bit into a parallel word, and flags parity mismatches. Parity is computed as a running XOR reduction, one xor_gate-equivalent operation per accepted bit. It sits downstream of a serial bit source and presents checked words to a parallel consumer through a valid/ready handshake. It also keeps a saturating count of parity errors.

---
 rtl/serial_parity_checker.sv | 122 ++++++++++++
 tb/tb_serial_parity_checker.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_parity_checker.sv
// Bit-serial receiver: assembles WORD_BITS data bits (LSB first) plus one parity bit, flags mismatch.
// Latency: out_valid rises on the edge accepting the parity bit; in_ready returns the cycle after the output handshake.
// Backpressure: while a frame is held (out_valid=1, out_ready=0) in_ready stays 0; in_ready decodes state only.
module serial_parity_checker #(
    parameter int WORD_BITS    = 8,
    parameter bit ODD          = 1'b0,
    parameter int ERR_CNT_BITS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_bit,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WORD_BITS-1:0]    out_word,
    output logic                    out_err,
    output logic [ERR_CNT_BITS-1:0] err_count
);

    localparam int                    CNT_W    = $clog2(WORD_BITS);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(WORD_BITS - 1);
    localparam logic [ERR_CNT_BITS-1:0] ERR_MAX = '1;

    typedef enum logic [1:0] {
        ST_DATA = 2'd0,
        ST_PAR  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    acc_q, acc_d;
    logic [WORD_BITS-1:0]    shreg_q, shreg_d;
    logic                    out_valid_q, out_valid_d;
    logic [WORD_BITS-1:0]    out_word_q, out_word_d;
    logic                    out_err_q, out_err_d;
    logic [ERR_CNT_BITS-1:0] err_count_q, err_count_d;
    logic                    err_new;

    // in_ready is a pure decode of registered state, so no path from out_ready
    assign in_ready  = (state_q != ST_HOLD);
    assign out_valid = out_valid_q;
    assign out_word  = out_word_q;
    assign out_err   = out_err_q;
    assign err_count = err_count_q;

    // Next-state: shift data bits in, fold them into parity, publish and hold the frame
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        shreg_d     = shreg_q;
        out_valid_d = out_valid_q;
        out_word_d  = out_word_q;
        out_err_d   = out_err_q;
        err_count_d = err_count_q;
        err_new     = 1'b0;
        case (state_q)
            ST_DATA: begin
                if (in_valid) begin
                    shreg_d[cnt_q] = in_bit;
                    acc_d          = acc_q ^ in_bit;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_PAR;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_PAR: begin
                if (in_valid) begin
                    err_new     = acc_q ^ in_bit ^ ODD;
                    out_word_d  = shreg_q;
                    out_err_d   = err_new;
                    out_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                    if (err_new && (err_count_q != ERR_MAX)) begin
                        err_count_d = err_count_q + 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                // out_word/out_err keep their values after the handshake
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    acc_d       = 1'b0;
                    shreg_d     = '0;
                    state_d     = ST_DATA;
                end
            end
            default: begin
                state_d = ST_DATA;
            end
        endcase
    end

    // State and output registers; reset discards any partial or held frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_DATA;
            cnt_q       <= '0;
            acc_q       <= 1'b0;
            shreg_q     <= '0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            out_err_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            shreg_q     <= shreg_d;
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            out_err_q   <= out_err_d;
            err_count_q <= err_count_d;
        end
    end

endmodule

// File: tb/tb_serial_parity_checker.sv
module tb_serial_parity_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0] in_valid  = 2'b00;
    logic [1:0] in_bit    = 2'b00;
    logic [1:0] out_ready = 2'b11;

    wire       in_ready0, out_valid0, out_err0;
    wire [7:0] out_word0, ec0;
    wire       in_ready1, out_valid1, out_err1;
    wire [7:0] out_word1;
    wire [1:0] ec1;

    // even parity, 8-bit counter
    serial_parity_checker #(.WORD_BITS(8), .ODD(1'b0), .ERR_CNT_BITS(8)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready0), .in_bit(in_bit[0]),
        .out_valid(out_valid0), .out_ready(out_ready[0]),
        .out_word(out_word0), .out_err(out_err0), .err_count(ec0)
    );

    // odd parity, 2-bit saturating counter
    serial_parity_checker #(.WORD_BITS(8), .ODD(1'b1), .ERR_CNT_BITS(2)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready1), .in_bit(in_bit[1]),
        .out_valid(out_valid1), .out_ready(out_ready[1]),
        .out_word(out_word1), .out_err(out_err1), .err_count(ec1)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] word;
        logic       err;
        logic [7:0] cnt;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    typedef struct {
        int         sel;
        logic [7:0] data;
        logic       par;
        int         gap;
        logic       exp_err;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic rdy(input int sel);
        return (sel == 0) ? in_ready0 : in_ready1;
    endfunction

    function automatic logic vld(input int sel);
        return (sel == 0) ? out_valid0 : out_valid1;
    endfunction

    task automatic drive_bit(input int sel, input logic b);
        int waited = 0;
        while (!rdy(sel) && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!rdy(sel)) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: dut%0d got in_ready 0, expected 1 within 50 cycles", sel);
        end
        in_valid[sel] = 1'b1;
        in_bit[sel]   = b;
        @(posedge clk);
        #1;
        in_valid[sel] = 1'b0;
    endtask

    task automatic send_frame(input int sel, input logic [7:0] data, input logic par, input int gap,
                              input logic exp_err, input logic [7:0] exp_cnt);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            drive_bit(sel, data[i]);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
        e.word = data;
        e.err  = exp_err;
        e.cnt  = exp_cnt;
        if (sel == 0) q0.push_back(e);
        else          q1.push_back(e);
        drive_bit(sel, par);
        check($sformatf("valid_rise dut%0d", sel), 32'(vld(sel)), 32'd1);
        if (out_ready[sel]) begin
            @(posedge clk);
            #1;
            check($sformatf("valid_pulse dut%0d", sel), 32'(vld(sel)), 32'd0);
            check($sformatf("ready_back dut%0d", sel), 32'(rdy(sel)), 32'd1);
        end
    endtask

    // Scoreboard: compare each frame at the negedge before its output handshake
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid0 && out_ready[0]) begin
                if (q0.size() == 0) begin
                    check("dut0_unexpected_frame", 32'd1, 32'd0);
                end else begin
                    e = q0.pop_front();
                    check("dut0_word", 32'(out_word0), 32'(e.word));
                    check("dut0_err", 32'(out_err0), 32'(e.err));
                    check("dut0_err_count", 32'(ec0), 32'(e.cnt));
                end
            end
            if (!rst && out_valid1 && out_ready[1]) begin
                if (q1.size() == 0) begin
                    check("dut1_unexpected_frame", 32'd1, 32'd0);
                end else begin
                    e = q1.pop_front();
                    check("dut1_word", 32'(out_word1), 32'(e.word));
                    check("dut1_err", 32'(out_err1), 32'(e.err));
                    check("dut1_err_count", 32'({6'd0, ec1}), 32'(e.cnt));
                end
            end
        end
    end

    initial begin
        // sel, data, parity, gap, expected err, expected err_count
        vecs[0] = '{0, 8'hA5, 1'b0, 0, 1'b0, 8'd0};
        vecs[1] = '{0, 8'hA5, 1'b1, 0, 1'b1, 8'd1};
        vecs[2] = '{0, 8'hFF, 1'b0, 0, 1'b0, 8'd1};
        vecs[3] = '{0, 8'h81, 1'b0, 3, 1'b0, 8'd1};
        vecs[4] = '{1, 8'h00, 1'b0, 0, 1'b1, 8'd1};
        vecs[5] = '{1, 8'h5A, 1'b0, 0, 1'b1, 8'd2};
        vecs[6] = '{1, 8'hFF, 1'b0, 1, 1'b1, 8'd3};
        vecs[7] = '{1, 8'h01, 1'b1, 0, 1'b1, 8'd3};
        vecs[8] = '{1, 8'h80, 1'b1, 0, 1'b1, 8'd3};
        vecs[9] = '{1, 8'h00, 1'b1, 0, 1'b0, 8'd3};

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid0), 32'd0);
        check("rst_out_word", 32'(out_word0), 32'd0);
        check("rst_out_err", 32'(out_err0), 32'd0);
        check("rst_err_count", 32'(ec0), 32'd0);
        check("rst_in_ready", 32'(in_ready0), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int v = 0; v < 10; v++) begin
            send_frame(vecs[v].sel, vecs[v].data, vecs[v].par, vecs[v].gap,
                       vecs[v].exp_err, vecs[v].exp_cnt);
        end

        // Backpressure: frame held while the source keeps offering bits
        out_ready[0] = 1'b0;
        send_frame(0, 8'h3C, 1'b0, 0, 1'b0, 8'd1);
        for (int i = 0; i < 5; i++) begin
            in_valid[0] = 1'b1;
            in_bit[0]   = i[0];
            @(posedge clk);
            #1;
            check("bp_out_valid", 32'(out_valid0), 32'd1);
            check("bp_in_ready", 32'(in_ready0), 32'd0);
            check("bp_out_word", 32'(out_word0), 32'h3C);
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_in_ready", 32'(in_ready0), 32'd1);
        check("bp_release_valid", 32'(out_valid0), 32'd0);
        check("bp_word_kept", 32'(out_word0), 32'h3C);
        send_frame(0, 8'h01, 1'b1, 0, 1'b0, 8'd1);

        // Reset mid-frame, asserted between clock edges
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid0), 32'd0);
        check("arst_out_word", 32'(out_word0), 32'd0);
        check("arst_out_err", 32'(out_err0), 32'd0);
        check("arst_err_count", 32'(ec0), 32'd0);
        check("arst_in_ready", 32'(in_ready0), 32'd1);
        check("arst_err_count_dut1", 32'(ec1), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_frame(0, 8'h0F, 1'b0, 0, 1'b0, 8'd0);

        repeat (3) @(posedge clk);
        #1;
        check("dut0_queue_drained", 32'(q0.size()), 32'd0);
        check("dut1_queue_drained", 32'(q1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

endmodule
